// File: rtl/drowsy_pkg.sv
// Shared types and constants for the drowsiness decision block.
package drowsy_pkg;

  localparam int unsigned SCORE_W = 10;

  typedef logic signed [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    AWAKE   = 2'd0,
    SUSPECT = 2'd1,
    ALARM   = 2'd2
  } state_e;

  localparam logic [1:0] CLS_ALERT  = 2'd0;
  localparam logic [1:0] CLS_TIRED  = 2'd1;
  localparam logic [1:0] CLS_DROWSY = 2'd2;

  // Accumulator weight of a classified frame; alert frames clear instead of adding.
  function automatic logic [1:0] cls_weight(input logic [1:0] cls);
    case (cls)
      CLS_ALERT: cls_weight = 2'd0;
      CLS_TIRED: cls_weight = 2'd1;
      default:   cls_weight = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/argmax_reg.sv
// Registered signed argmax over NUM_CLASS scores (lowest index wins ties).
// With SCORE_MARGIN_EN defined, frames whose winner/runner-up gap is below MARGIN are not classified.
module argmax_reg #(
  parameter int unsigned NUM_CLASS = 3,
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned MARGIN    = 16
) (
  input  logic                     Clock,
  input  logic                     Rst,
  input  logic                     InValid,
  input  logic signed [DATA_W-1:0] Score [0:NUM_CLASS-1],
  output logic [1:0]               ClassIdx,
  output logic                     ClassValid
);

  logic signed [DATA_W-1:0] w_best;
  logic [1:0]               w_idx;
  logic                     w_certain;
`ifdef SCORE_MARGIN_EN
  logic signed [DATA_W-1:0] w_second;
  logic signed [DATA_W:0]   w_gap;
`endif

  always_comb begin
    w_best = Score[0];
    w_idx  = '0;
`ifdef SCORE_MARGIN_EN
    w_second = Score[1];
`endif
    for (int unsigned i = 1; i < NUM_CLASS; i++) begin
      if (Score[i] > w_best) begin
`ifdef SCORE_MARGIN_EN
        w_second = w_best;
`endif
        w_best = Score[i];
        w_idx  = 2'(i);
      end
`ifdef SCORE_MARGIN_EN
      else if (Score[i] > w_second) begin
        w_second = Score[i];
      end
`endif
    end
`ifdef SCORE_MARGIN_EN
    // One extra bit keeps the gap exact across the full signed range.
    w_gap     = {w_best[DATA_W-1], w_best} - {w_second[DATA_W-1], w_second};
    w_certain = (w_gap >= $signed((DATA_W+1)'(MARGIN)));
`else
    w_certain = 1'b1;
`endif
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      ClassIdx   <= '0;
      ClassValid <= 1'b0;
    end else begin
      ClassValid <= InValid & w_certain;
      if (InValid) ClassIdx <= w_idx;
    end
  end

endmodule

// File: rtl/drowsiness_decision.sv
// Argmax of per-frame scores followed by a temporal filter raising Warn/Alarm.
// Optional macro SCORE_MARGIN_EN drops frames with an insufficient winner margin.
module drowsiness_decision
  import drowsy_pkg::*;
#(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned NUM_CLASS    = 3,
  parameter int unsigned ALARM_TH     = 8,
  parameter int unsigned CLEAR_FRAMES = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned MARGIN       = 16
) (
  input  logic                     Clock,
  input  logic                     Rst,
  input  logic                     InValid,
  input  logic signed [DATA_W-1:0] Score [0:NUM_CLASS-1],
  input  logic                     Ack,
  output logic [1:0]               ClassIdx,
  output logic                     ClassValid,
  output logic [CNT_W-1:0]         Acc,
  output logic [1:0]               State,
  output logic                     Warn,
  output logic                     Alarm
);

  logic [1:0]       w_cls_idx;
  logic             w_cls_valid;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_clr_next;
  logic             w_ack_eff;

  state_e           r_state;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_clr;
  logic             r_ack_seen;
  logic             r_warn;
  logic             r_alarm;

  argmax_reg #(
    .NUM_CLASS (NUM_CLASS),
    .DATA_W    (DATA_W),
    .MARGIN    (MARGIN)
  ) u_argmax (
    .Clock      (Clock),
    .Rst        (Rst),
    .InValid    (InValid),
    .Score      (Score),
    .ClassIdx   (w_cls_idx),
    .ClassValid (w_cls_valid)
  );

  always_comb begin
    w_sum = {1'b0, r_acc} + (CNT_W+1)'(cls_weight(w_cls_idx));
    if (w_cls_idx == CLS_ALERT) w_acc_next = '0;
    else if (w_sum[CNT_W])      w_acc_next = '1;
    else                        w_acc_next = w_sum[CNT_W-1:0];

    // Clear counter parks at CLEAR_FRAMES so a late Ack releases on the next alert frame.
    if (w_cls_idx != CLS_ALERT)                 w_clr_next = '0;
    else if (r_clr >= CNT_W'(CLEAR_FRAMES))     w_clr_next = r_clr;
    else                                        w_clr_next = r_clr + CNT_W'(1);

    w_ack_eff = r_ack_seen | Ack;
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      r_state    <= AWAKE;
      r_acc      <= '0;
      r_clr      <= '0;
      r_ack_seen <= 1'b0;
      r_warn     <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      case (r_state)
        ALARM: begin
          if (w_cls_valid) begin
            if (w_clr_next == CNT_W'(CLEAR_FRAMES) && w_ack_eff) begin
              r_state    <= AWAKE;
              r_acc      <= '0;
              r_clr      <= '0;
              r_ack_seen <= 1'b0;
              r_warn     <= 1'b0;
              r_alarm    <= 1'b0;
            end else begin
              r_clr      <= w_clr_next;
              r_ack_seen <= w_ack_eff;
            end
          end else if (Ack) begin
            r_ack_seen <= 1'b1;
          end
        end
        default: begin
          if (w_cls_valid) begin
            r_acc <= w_acc_next;
            if (w_acc_next >= CNT_W'(ALARM_TH)) begin
              r_state <= ALARM;
              r_warn  <= 1'b0;
              r_alarm <= 1'b1;
            end else if (w_acc_next != '0) begin
              r_state <= SUSPECT;
              r_warn  <= 1'b1;
              r_alarm <= 1'b0;
            end else begin
              r_state <= AWAKE;
              r_warn  <= 1'b0;
              r_alarm <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign ClassIdx   = w_cls_idx;
  assign ClassValid = w_cls_valid;
  assign Acc        = r_acc;
  assign State      = r_state;
  assign Warn       = r_warn;
  assign Alarm      = r_alarm;

endmodule

// File: tb/tb_drowsiness_decision.sv
// Self-checking bench for drowsiness_decision against a frame-level reference model.
module tb_drowsiness_decision;
  import drowsy_pkg::*;

  logic       Clock;
  logic       Rst;
  logic       InValid;
  score_t     sc [0:2];
  logic       Ack;
  logic [1:0] ClassIdx;
  logic       ClassValid;
  logic [7:0] Acc;
  logic [1:0] State;
  logic       Warn;
  logic       Alarm;

  int checks = 0;
  int errors = 0;

  // Reference model: pending classification and filter status as plain integers.
  bit m_pv;
  int m_pidx, m_state, m_acc, m_clr;
  bit m_ack;

  drowsiness_decision #(
    .DATA_W(10), .NUM_CLASS(3), .ALARM_TH(8), .CLEAR_FRAMES(4), .CNT_W(8), .MARGIN(16)
  ) dut (
    .Clock(Clock), .Rst(Rst), .InValid(InValid), .Score(sc), .Ack(Ack),
    .ClassIdx(ClassIdx), .ClassValid(ClassValid), .Acc(Acc), .State(State),
    .Warn(Warn), .Alarm(Alarm)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic void ref_class(input int a, input int b, input int c,
                                    output int idx, output bit ok);
    int s[3];
    int runner;
    s = '{a, b, c};
    idx = 0;
    for (int i = 1; i < 3; i++) if (s[i] > s[idx]) idx = i;
    runner = -100000;
    for (int j = 0; j < 3; j++) if (j != idx && s[j] > runner) runner = s[j];
`ifdef SCORE_MARGIN_EN
    ok = (s[idx] - runner) >= 16;
`else
    ok = 1'b1;
`endif
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [1:0] idx;
    idx = m_pv ? 2'(m_pidx) : 2'd0;
    return {idx, m_pv, 8'(m_acc), 2'(m_state), m_state == 1, m_state == 2};
  endfunction

  function automatic logic [14:0] got_vec();
    return {(ClassValid ? ClassIdx : 2'd0), ClassValid, Acc, State, Warn, Alarm};
  endfunction

  task automatic tick(input bit v, input int a, input int b, input int c,
                      input bit ack, input bit rst);
    int idx;
    bit ok;
    InValid = v; sc[0] = score_t'(a); sc[1] = score_t'(b); sc[2] = score_t'(c);
    Ack = ack; Rst = rst;
    @(posedge Clock);
    if (rst) begin
      m_pv = 0; m_pidx = 0; m_state = 0; m_acc = 0; m_clr = 0; m_ack = 0;
    end else begin
      if (m_state == 2) begin
        if (m_pv) begin
          if (m_pidx == 0) m_clr = (m_clr < 4) ? m_clr + 1 : 4;
          else             m_clr = 0;
          if (m_clr == 4 && (m_ack || ack)) begin
            m_state = 0; m_acc = 0; m_clr = 0; m_ack = 0;
          end else begin
            m_ack = m_ack || ack;
          end
        end else if (ack) begin
          m_ack = 1;
        end
      end else if (m_pv) begin
        m_acc = (m_pidx == 0) ? 0 : ((m_acc + m_pidx > 255) ? 255 : m_acc + m_pidx);
        m_state = (m_acc >= 8) ? 2 : ((m_acc > 0) ? 1 : 0);
      end
      ref_class(a, b, c, idx, ok);
      m_pv = v && ok;
      if (v) m_pidx = idx;
    end
    #1;
  endtask

  // Stimulus-only helpers for well-separated class frames.
  task automatic frame(input int cls, input bit ack);
    case (cls)
      0:       tick(1, 90, 0, -10, ack, 0);
      1:       tick(1, 0, 90, -10, ack, 0);
      default: tick(1, -10, 0, 90, ack, 0);
    endcase
  endtask

  task automatic idle(input bit ack);
    tick(0, 0, 0, 0, ack, 0);
  endtask

  task automatic go_alarm();
    tick(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) frame(2, 0);
    idle(0);
  endtask

  task automatic test_reset();
    tick(1, 5, 6, 7, 1, 1);
    tick(0, 0, 0, 0, 0, 1);
    checks++;
    if ({ClassIdx, ClassValid, Acc, State, Warn, Alarm} !== 15'd0) begin
      errors++;
      $display("FAIL reset got=%h exp=0", {ClassIdx, ClassValid, Acc, State, Warn, Alarm});
    end
  endtask

  task automatic test_argmax();
    int a, b, c;
    tick(0, 0, 0, 0, 0, 1);
    tick(1, 100, 20, -5, 0, 0);
    checks++;
    if (ClassValid !== 1'b1 || ClassIdx !== 2'd0) begin
      errors++; $display("FAIL argmax_basic got=%0d/%0d exp=1/0", ClassValid, ClassIdx);
    end
    idle(0);
    checks++;
    if (ClassValid !== 1'b0 || State !== 2'd0 || Acc !== 8'd0) begin
      errors++; $display("FAIL argmax_idle got=%0d/%0d/%0d exp=0/0/0", ClassValid, State, Acc);
    end
    tick(1, 50, 50, 10, 0, 0);
    checks++;
`ifdef SCORE_MARGIN_EN
    if (ClassValid !== 1'b0) begin
      errors++; $display("FAIL argmax_tie got=%0d exp=0", ClassValid);
    end
`else
    if (ClassValid !== 1'b1 || ClassIdx !== 2'd0) begin
      errors++; $display("FAIL argmax_tie got=%0d/%0d exp=1/0", ClassValid, ClassIdx);
    end
`endif
    tick(1, 511, -512, -512, 0, 0);
    checks++;
    if (ClassValid !== 1'b1 || ClassIdx !== 2'd0) begin
      errors++; $display("FAIL argmax_ext0 got=%0d/%0d exp=1/0", ClassValid, ClassIdx);
    end
    tick(1, -512, -512, 511, 0, 0);
    checks++;
    if (ClassValid !== 1'b1 || ClassIdx !== 2'd2) begin
      errors++; $display("FAIL argmax_ext2 got=%0d/%0d exp=1/2", ClassValid, ClassIdx);
    end
    tick(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(1023)) - 512;
      b = int'($urandom_range(1023)) - 512;
      c = ($urandom_range(3) == 0) ? a : int'($urandom_range(1023)) - 512;
      tick(1, a, b, c, 0, (n % 8) == 7);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL argmax_rand n=%0d got=%h exp=%h", n, got_vec(), exp_vec());
      end
    end
  endtask

`ifdef SCORE_MARGIN_EN
  task automatic test_margin();
    tick(0, 0, 0, 0, 0, 1);
    tick(1, 40, 30, 0, 0, 0);
    checks++;
    if (ClassValid !== 1'b0) begin
      errors++; $display("FAIL margin_low got=%0d exp=0", ClassValid);
    end
    tick(1, 45, 30, 0, 0, 0);
    checks++;
    if (ClassValid !== 1'b0 || State !== 2'd0) begin
      errors++; $display("FAIL margin_15 got=%0d/%0d exp=0/0", ClassValid, State);
    end
    tick(1, 46, 30, 0, 0, 0);
    checks++;
    if (ClassValid !== 1'b1 || ClassIdx !== 2'd0) begin
      errors++; $display("FAIL margin_16 got=%0d/%0d exp=1/0", ClassValid, ClassIdx);
    end
    tick(1, 60, 30, 0, 0, 0);
    checks++;
    if (ClassValid !== 1'b1 || ClassIdx !== 2'd0) begin
      errors++; $display("FAIL margin_ok got=%0d/%0d exp=1/0", ClassValid, ClassIdx);
    end
  endtask
`endif

  task automatic test_alarm_entry();
    tick(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      frame(2, 0);
      checks++;
      if (Acc !== 8'(2 * k) || Warn !== (k > 0) || Alarm !== 1'b0) begin
        errors++; $display("FAIL entry k=%0d got acc=%0d warn=%0d alarm=%0d exp acc=%0d", k, Acc, Warn, Alarm, 2 * k);
      end
    end
    for (int k = 0; k < 2; k++) begin
      idle(0);
      checks++;
      if (Acc !== 8'd8 || Alarm !== 1'b1 || Warn !== 1'b0 || State !== 2'd2) begin
        errors++; $display("FAIL entry_alarm k=%0d got acc=%0d alarm=%0d state=%0d exp 8/1/2", k, Acc, Alarm, State);
      end
    end
  endtask

  task automatic test_ack_release();
    for (int k = 0; k < 5; k++) frame(0, 0);
    idle(0);
    idle(0);
    checks++;
    if (Alarm !== 1'b1 || Acc !== 8'd8) begin
      errors++; $display("FAIL noack_hold got alarm=%0d acc=%0d exp 1/8", Alarm, Acc);
    end
    idle(1);
    frame(0, 0);
    checks++;
    if (Alarm !== 1'b1) begin
      errors++; $display("FAIL ack_pending got alarm=%0d exp 1", Alarm);
    end
    idle(0);
    checks++;
    if (State !== 2'd0 || Acc !== 8'd0 || Alarm !== 1'b0 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL ack_release got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_clear_restart();
    int seq[7] = '{0, 0, 1, 0, 0, 0, 0};
    go_alarm();
    idle(1);
    for (int k = 0; k < 7; k++) begin
      frame(seq[k], 0);
      checks++;
      if (Alarm !== 1'b1 || got_vec() !== exp_vec()) begin
        errors++; $display("FAIL clear_hold k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
      end
    end
    idle(0);
    checks++;
    if (State !== 2'd0 || Alarm !== 1'b0 || Acc !== 8'd0) begin
      errors++; $display("FAIL clear_exit got state=%0d alarm=%0d acc=%0d exp 0/0/0", State, Alarm, Acc);
    end
  endtask

  task automatic test_suspect_clear();
    tick(0, 0, 0, 0, 0, 1);
    frame(1, 0);
    frame(2, 0);
    idle(0);
    checks++;
    if (Acc !== 8'd3 || State !== 2'd1 || Warn !== 1'b1) begin
      errors++; $display("FAIL suspect got acc=%0d state=%0d warn=%0d exp 3/1/1", Acc, State, Warn);
    end
    frame(0, 1);
    idle(0);
    checks++;
    if (Acc !== 8'd0 || State !== 2'd0 || Warn !== 1'b0) begin
      errors++; $display("FAIL suspect_clear got acc=%0d state=%0d warn=%0d exp 0/0/0", Acc, State, Warn);
    end
  endtask

  task automatic test_reset_midflight();
    go_alarm();
    tick(1, -10, 0, 90, 1, 1);
    checks++;
    if ({ClassIdx, ClassValid, Acc, State, Warn, Alarm} !== 15'd0) begin
      errors++; $display("FAIL reset_mid got=%h exp=0", {ClassIdx, ClassValid, Acc, State, Warn, Alarm});
    end
    idle(0);
    checks++;
    if (ClassValid !== 1'b0 || State !== 2'd0) begin
      errors++; $display("FAIL reset_drop got valid=%0d state=%0d exp 0/0", ClassValid, State);
    end
  endtask

  task automatic test_back_to_back_random();
    int a, b, c, w;
    tick(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      w = int'($urandom_range(9));
      a = int'($urandom_range(200)) - 100;
      b = int'($urandom_range(200)) - 100;
      c = int'($urandom_range(200)) - 100;
      if (w < 3)      a = a + 300;
      else if (w < 5) b = b + 300;
      else if (w < 9) c = c + 300;
      tick($urandom_range(7) != 0, a, b, c, $urandom_range(7) == 0, $urandom_range(599) == 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL random n=%0d got=%h exp=%h", n, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    Rst = 1'b1; InValid = 1'b0; Ack = 1'b0;
    sc[0] = '0; sc[1] = '0; sc[2] = '0;
    m_pv = 0; m_pidx = 0; m_state = 0; m_acc = 0; m_clr = 0; m_ack = 0;
    test_reset();
    test_argmax();
`ifdef SCORE_MARGIN_EN
    test_margin();
`endif
    test_alarm_entry();
    test_ack_release();
    test_clear_restart();
    test_suspect_clear();
    test_reset_midflight();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/drowsiness_decision.md
Name: drowsiness_decision

Overview:
- Downstream consumer of the hidden/output-layer network. Takes the NUM_CLASS signed output-layer scores per frame.
- Registers an argmax class per frame, then runs a temporal-filter FSM. Raises Warn/Alarm on sustained drowsiness.
- Alarm release requires an operator Ack plus a run of consecutive alert frames.
- Feeds the alarm driver / top-level status.

Parameters:
- DATA_W, 10, score width (signed two's complement)
- NUM_CLASS, 3, number of scores; class 0 = alert, 1 = tired, 2 = eyes-closed/drowsy
- ALARM_TH, 8, accumulator value at or above which ALARM is entered
- CLEAR_FRAMES, 4, consecutive class-0 frames needed to leave ALARM
- CNT_W, 8, width of accumulator and clear counter
- MARGIN, 16, minimum winner-over-runner-up gap (used only with SCORE_MARGIN_EN)

Ports:
- Clock  in  1  system clock, rising edge
- Rst  in  1  synchronous, active-high reset
- InValid  in  1  Score is a valid frame this cycle; one frame per cycle max, no backpressure
- Score[0:NUM_CLASS-1]  in  DATA_W each, signed  output-layer scores
- Ack  in  1  operator acknowledge pulse
- ClassIdx  out  2  registered argmax index
- ClassValid  out  1  ClassIdx valid, 1-cycle strobe
- Acc  out  CNT_W  drowsiness accumulator
- State  out  2  FSM state encoding
- Warn  out  1  high in SUSPECT
- Alarm  out  1  high in ALARM

Behaviour:
- Reset (Rst=1 at a Clock edge): ClassIdx=0, ClassValid=0, Acc=0, ClearCnt=0, AckSeen=0, State=AWAKE, Warn=0, Alarm=0. Rst has priority over all inputs and mid-operation activity; a frame in flight is dropped.
- Stage 1, argmax:
  - Frame is sampled on the edge where InValid=1; ClassIdx/ClassValid appear at t+1.
  - Comparison is signed. On ties the lowest index wins.
  - ClassValid=0 when no frame was sampled.
- Stage 2, FSM: acts on the ClassValid cycle, so State/Acc/Alarm update at t+2. Nothing changes without ClassValid, except AckSeen capture.
- Accumulator update per classified frame:
  - class0 sets Acc to 0.
  - class1 adds 1.
  - class2 adds 2.
  - Acc saturates at 2^CNT_W-1 and never wraps.
- States AWAKE=0, SUSPECT=1, ALARM=2.
- AWAKE and SUSPECT transitions, using the new Acc:
  - new Acc >= ALARM_TH goes to ALARM.
  - else Acc>0 goes to SUSPECT.
  - else goes to AWAKE.
- ALARM:
  - Acc is frozen.
  - Ack=1 on any cycle sets AckSeen. AckSeen is sticky.
  - A class0 frame increments ClearCnt. A class1 or class2 frame sets ClearCnt to 0.
  - When ClearCnt reaches CLEAR_FRAMES with AckSeen=1 (including an Ack on that same cycle), go to AWAKE and clear Acc, ClearCnt and AckSeen.
  - If ClearCnt reaches CLEAR_FRAMES without AckSeen, ClearCnt saturates there. Exit happens on the first class0 frame after Ack.
- Ack outside ALARM is ignored.
- Warn = (State==SUSPECT). Alarm = (State==ALARM). Both are registered outputs.
- Back-to-back frames are supported every cycle with no bubble.

Optional Feature:
- Macro: SCORE_MARGIN_EN.
- Defined:
  - Stage 1 also tracks the runner-up score.
  - If winner - runner-up < MARGIN (computed at DATA_W+1 bits signed, no overflow), the frame is uncertain.
  - An uncertain frame has ClassValid=0 and changes no state.
- Undefined: every valid frame is classified; the MARGIN parameter is unused.

Decomposition:
- Package drowsy_pkg:
  - state enum (AWAKE, SUSPECT, ALARM)
  - class constants CLS_ALERT=0, CLS_TIRED=1, CLS_DROWSY=2
  - score typedef (signed DATA_W)
- Sub-module argmax_reg:
  - parameterised NUM_CLASS/DATA_W registered argmax, with runner-up/margin under the macro
  - instantiated once; the FSM lives in the top.

Test Plan:
- Reset then a frame of Score={100,20,-5} → ClassIdx=0, ClassValid at t+1, State AWAKE, Acc=0. Ties {50,50,10} → ClassIdx=0.
- 4 consecutive {-10,0,90} frames → Acc 2,4,6,8. Warn during frames 1-3; Alarm asserts 2 cycles after the 4th frame; Acc frozen at 8.
- In ALARM, 5 class0 frames with no Ack → stays ALARM. Then Ack pulse plus 1 class0 frame → AWAKE, Acc=0, Alarm=0.
- In ALARM, Ack, then class0,class0,class1,class0×4 → ClearCnt resets at the class1 frame; exit to AWAKE only after the 4th trailing class0.
- SUSPECT with Acc=3, then one class0 frame → AWAKE, Acc=0. Rst=1 asserted in ALARM with InValid=1 → all outputs 0 the next cycle.
- SCORE_MARGIN_EN with MARGIN=16: {40,30,0} → no ClassValid, state unchanged. {60,30,0} → ClassIdx=0. Signed extremes {511,-512,-512} give no overflow.
